tx_chan_scheduler: RTL and testbench

//  Round-robin scheduler that shares one packet-reader port among NCH channel_ram packet FIFOs on txclk.

---
 rtl/tx_sched_pkg.sv | 19 +
 rtl/tx_chan_scheduler_rr_pick.sv | 34 +++
 rtl/tx_chan_scheduler.sv | 138 +++++++++++++
 tb/tb_tx_chan_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/tx_sched_pkg.sv
// Shared definitions for the tx channel scheduler: FSM encoding, sizing helper, channel limit.
package tx_sched_pkg;

  localparam int MAX_NCH = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } sched_state_t;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/tx_chan_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping NCH-1 -> 0.
module rr_pick
  import tx_sched_pkg::*;
#(
  parameter int NCH = 3,
  parameter int PW  = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic           found,
  output logic [PW-1:0]  idx
);

  int            c_int;
  logic [PW-1:0] c;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    c_int = 0;
    c     = '0;
    for (int i = 0; i < NCH; i++) begin
      // explicit wrap so non-power-of-two NCH never aliases onto a missing channel
      c_int = int'(ptr) + i;
      if (c_int >= NCH) c_int = c_int - NCH;
      c = PW'(c_int);
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = c;
      end
    end
  end

endmodule

// File: rtl/tx_chan_scheduler.sv
// Round-robin arbiter sharing one packet reader among NCH channel RAMs, with a hold watchdog.
// Optional: define TX_SCHED_CMD_PRIORITY_EN to let channel CMD_IDX jump the rotation.
module tx_chan_scheduler
  import tx_sched_pkg::*;
#(
  parameter int NCH      = 3,
  parameter int CMD_IDX  = 2,
  parameter int MAX_HOLD = 2048
) (
  input  logic              txclk,
  input  logic              reset,
  input  logic [NCH-1:0]    pkt_waiting,
  input  logic [32*NCH-1:0] fifodata,
  input  logic              rd_req,
  input  logic              rd_done,
  output logic [NCH-1:0]    chan_rdreq,
  output logic [NCH-1:0]    chan_done,
  output logic [31:0]       dataout,
  output logic [NCH-1:0]    grant,
  output logic              grant_valid,
  output logic              timeout,
  output logic [2:0]        timeout_chan
);

  localparam int PW = (clog2(NCH) < 1) ? 1 : clog2(NCH);
  localparam int CW = (clog2(MAX_HOLD) < 1) ? 1 : clog2(MAX_HOLD);

  if (NCH < 2 || NCH > MAX_NCH) begin : g_bad_nch
    $error("tx_chan_scheduler: NCH out of range");
  end
  if (CMD_IDX < 0 || CMD_IDX >= NCH) begin : g_bad_cmd
    $error("tx_chan_scheduler: CMD_IDX out of range");
  end
  if (MAX_HOLD < 4) begin : g_bad_hold
    $error("tx_chan_scheduler: MAX_HOLD too small");
  end

  sched_state_t  state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [CW-1:0] hold_cnt;
  logic          cmd_grant;
  logic          pick_found;
  logic [PW-1:0] pick_idx;
  logic          wd_hit;
  logic [PW-1:0] ptr_next;

  rr_pick #(
    .NCH (NCH),
    .PW  (PW)
  ) u_rr_pick (
    .req   (pkt_waiting),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // rd_done takes precedence over the watchdog when both land on the same cycle
  assign wd_hit   = (state == ST_BUSY) && (hold_cnt == CW'(MAX_HOLD - 1)) && !rd_done;
  assign ptr_next = (gidx == PW'(NCH - 1)) ? '0 : gidx + 1'b1;

  always_ff @(posedge txclk) begin
    if (reset) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      gidx         <= '0;
      hold_cnt     <= '0;
      cmd_grant    <= 1'b0;
      grant        <= '0;
      grant_valid  <= 1'b0;
      timeout      <= 1'b0;
      timeout_chan <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
`ifdef TX_SCHED_CMD_PRIORITY_EN
          if (pkt_waiting[CMD_IDX]) begin
            grant       <= NCH'(1) << CMD_IDX;
            gidx        <= PW'(CMD_IDX);
            cmd_grant   <= 1'b1;
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
            state       <= ST_BUSY;
          end else
`endif
          if (pick_found) begin
            grant       <= NCH'(1) << pick_idx;
            gidx        <= pick_idx;
            cmd_grant   <= 1'b0;
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
            state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (rd_done) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            state       <= ST_RELEASE;
          end else if (wd_hit) begin
            grant        <= '0;
            grant_valid  <= 1'b0;
            timeout      <= 1'b1;
            timeout_chan <= 3'(gidx);
            state        <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          // a command-channel grant leaves the data rotation where it was
          if (!cmd_grant) ptr <= ptr_next;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    chan_rdreq = '0;
    chan_done  = '0;
    if (state == ST_BUSY) begin
      chan_rdreq = grant & {NCH{rd_req}};
      chan_done  = grant & {NCH{rd_done | wd_hit}};
    end
  end

  always_comb begin
    dataout = '0;
    if (grant_valid) begin
      for (int k = 0; k < NCH; k++) begin
        if (grant[k]) dataout = fifodata[32*k +: 32];
      end
    end
  end

endmodule

// File: tb/tb_tx_chan_scheduler.sv
// Directed bench for tx_chan_scheduler (NCH=3, MAX_HOLD=16); follows TX_SCHED_CMD_PRIORITY_EN.
module tb_tx_chan_scheduler;

  localparam int NCH = 3;

  logic              txclk;
  logic              reset;
  logic [NCH-1:0]    pkt_waiting;
  logic [32*NCH-1:0] fifodata;
  logic              rd_req;
  logic              rd_done;
  logic [NCH-1:0]    chan_rdreq;
  logic [NCH-1:0]    chan_done;
  logic [31:0]       dataout;
  logic [NCH-1:0]    grant;
  logic              grant_valid;
  logic              timeout;
  logic [2:0]        timeout_chan;

  int vectors     = 0;
  int miscompares = 0;

  tx_chan_scheduler #(
    .NCH      (NCH),
    .CMD_IDX  (2),
    .MAX_HOLD (16)
  ) dut (
    .txclk        (txclk),
    .reset        (reset),
    .pkt_waiting  (pkt_waiting),
    .fifodata     (fifodata),
    .rd_req       (rd_req),
    .rd_done      (rd_done),
    .chan_rdreq   (chan_rdreq),
    .chan_done    (chan_done),
    .dataout      (dataout),
    .grant        (grant),
    .grant_valid  (grant_valid),
    .timeout      (timeout),
    .timeout_chan (timeout_chan)
  );

  initial txclk = 1'b0;
  always #5 txclk = ~txclk;

  task automatic tick();
    @(posedge txclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL time_limit: bench did not complete");
    $fatal(1, "time limit");
  end

  logic [2:0] rot_exp [6];

  initial begin
`ifdef TX_SCHED_CMD_PRIORITY_EN
    rot_exp = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
`else
    rot_exp = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
`endif
    reset       = 1'b1;
    pkt_waiting = '0;
    rd_req      = 1'b0;
    rd_done     = 1'b0;
    fifodata    = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    repeat (3) tick();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_valid", 32'(grant_valid), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_tchan", 32'(timeout_chan), 32'h0);

    // strobes with no grant must not reach any RAM
    reset   = 1'b0;
    rd_req  = 1'b1;
    rd_done = 1'b1;
    #1;
    chk("idle_rdreq", 32'(chan_rdreq), 32'h0);
    chk("idle_done", 32'(chan_done), 32'h0);
    chk("idle_data", dataout, 32'h0);
    tick();
    chk("idle_valid", 32'(grant_valid), 32'h0);
    rd_req  = 1'b0;
    rd_done = 1'b0;

    // single request on ch0, done on 10th busy cycle
    pkt_waiting = 3'b001;
    tick();
    chk("single_grant", 32'(grant), 32'h1);
    chk("single_valid", 32'(grant_valid), 32'h1);
    chk("single_data", dataout, 32'hAAAA0000);
    pkt_waiting = '0;
    repeat (9) tick();
    rd_done = 1'b1;
    #1;
    chk("single_done", 32'(chan_done), 32'h1);
    tick();
    rd_done = 1'b0;
    chk("single_rel_grant", 32'(grant), 32'h0);
    chk("single_rel_valid", 32'(grant_valid), 32'h0);
    #1;
    chk("single_rel_done", 32'(chan_done), 32'h0);

    // pointer now 1: ch1 wins over ch0, after one RELEASE and one IDLE cycle
    pkt_waiting = 3'b011;
    tick();
    chk("gap_valid", 32'(grant_valid), 32'h0);
    tick();
    chk("ptr1_grant", 32'(grant), 32'h2);
    chk("route_data", dataout, 32'hBBBB0001);
    pkt_waiting = '0;
    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1;
      #1;
      chk("route_rdreq", 32'(chan_rdreq), 32'h2);
      tick();
    end
    rd_req = 1'b0;
    #1;
    chk("route_rdreq_off", 32'(chan_rdreq), 32'h0);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;

    // rotation from pointer 2 with all channels waiting
    pkt_waiting = 3'b111;
    for (int k = 0; k < 6; k++) begin
      tick();
      tick();
      chk($sformatf("rot_%0d", k), 32'(grant), 32'(rot_exp[k]));
      repeat (4) tick();
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
    end

    // watchdog on ch2: forced release on the 16th busy cycle
    pkt_waiting = 3'b100;
    tick();
    tick();
    chk("wd_grant", 32'(grant), 32'h4);
    pkt_waiting = 3'b001;
    repeat (14) tick();
    chk("wd_cyc15_done", 32'(chan_done), 32'h0);
    tick();
    chk("wd_cyc16_done", 32'(chan_done), 32'h4);
    chk("wd_cyc16_tout", 32'(timeout), 32'h0);
    tick();
    chk("wd_tout", 32'(timeout), 32'h1);
    chk("wd_tchan", 32'(timeout_chan), 32'h2);
    chk("wd_rel_grant", 32'(grant), 32'h0);
    tick();
    chk("wd_tout_pulse", 32'(timeout), 32'h0);
    tick();
    chk("wd_next_grant", 32'(grant), 32'h1);

    // rd_done on the watchdog cycle: normal release, no timeout
    pkt_waiting = '0;
    repeat (15) tick();
    rd_done = 1'b1;
    #1;
    chk("coll_done", 32'(chan_done), 32'h1);
    tick();
    rd_done = 1'b0;
    chk("coll_tout", 32'(timeout), 32'h0);
    chk("coll_grant", 32'(grant), 32'h0);
    chk("coll_tchan", 32'(timeout_chan), 32'h2);

    // reset while busy, then priority behaviour from pointer 0
    pkt_waiting = 3'b010;
    tick();
    tick();
    chk("rb_grant", 32'(grant), 32'h2);
    reset = 1'b1;
    tick();
    chk("rb_grant_off", 32'(grant), 32'h0);
    chk("rb_valid_off", 32'(grant_valid), 32'h0);
    reset       = 1'b0;
    pkt_waiting = 3'b101;
    tick();
`ifdef TX_SCHED_CMD_PRIORITY_EN
    chk("prio_first", 32'(grant), 32'h4);
    pkt_waiting = 3'b001;
`else
    chk("prio_first", 32'(grant), 32'h1);
`endif
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    tick();
    tick();
`ifdef TX_SCHED_CMD_PRIORITY_EN
    chk("prio_second", 32'(grant), 32'h1);
`else
    chk("prio_second", 32'(grant), 32'h4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
